cam_sccb_init_ctrl: RTL and testbench
=====================================

// Module: cam_sccb_init_ctrl
// PURPOSE
//  Power-up sequencer and SCCB register loader for the OV5640 camera port.
//  Drives cmos_pwdn and cmos_rst_n timing, then walks an external register table and
//  issues 3-phase SCCB writes (ID, reg addr hi, reg addr lo, data) over open-drain SCL/SDA.
//  Asserts cam_init_done for the camera user interface once every entry is written.
//  Sits between the board cmos_scl/cmos_sda/cmos_pwdn/cmos_rst_n pins and the table ROM.
// PARAMETERS
//  CLK_FREQ     50_000_000  clk frequency, Hz
//  SCL_FREQ     100_000     SCL frequency, Hz; QDIV = CLK_FREQ/(4*SCL_FREQ), must be >= 1
//  DEV_ADDR     8'h78       SCCB write ID
//  REG_NUM      256         table entries, indices 0..REG_NUM-1, REG_NUM <= 256
//  PWDN_CYC     250_000     cycles with pwdn=1 after start
//  RST_CYC      50_000      cycles with rst_n=0 after pwdn release
//  SETTLE_CYC   1_000_000   cycles after rst_n release before the first write
//  MS_CYC       50_000      cycles per 1 ms unit, used by delay entries
//  MAX_RETRY    3           retries per entry after a NACK
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  start        in   1   one-cycle pulse; begins the sequence from IDLE, DONE or ERR
//  lut_index    out  8   table address
//  lut_data     in   24  {reg_addr[15:0], data[7:0]}; valid 1 cycle after lut_index changes
//  cmos_pwdn    out  1   camera power down, 1 = powered down
//  cmos_rst_n   out  1   camera reset, 0 = in reset
//  scl_oe       out  1   1 = pull cmos_scl low; 0 = release the line (pull-up)
//  sda_oe       out  1   1 = pull cmos_sda low; 0 = release the line
//  sda_i        in   1   sampled cmos_sda level
//  busy         out  1   high from start until DONE or ERR
//  cam_init_done out 1   high in DONE, level
//  init_err     out  1   high in ERR, level
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) from any state: go to IDLE with cmos_pwdn=1, cmos_rst_n=0,
//   scl_oe=0, sda_oe=0, busy=0, cam_init_done=0, init_err=0, lut_index=0, all counters 0.
//   A reset mid-transfer releases both bus lines on the next edge. No STOP condition is sent.
//  States and transitions:
//   IDLE -> PWDN when start=1.
//   PWDN: cmos_pwdn=1 and cmos_rst_n=0 for PWDN_CYC cycles.
//   RST: cmos_pwdn=0 and cmos_rst_n=0 for RST_CYC cycles.
//   SETTLE: cmos_rst_n=1 for SETTLE_CYC cycles, then LOAD.
//   LOAD: wait 1 cycle for the table, latch lut_data.
//    If reg_addr==16'hFFFF, go to DELAY for data*MS_CYC cycles; data=0 means no delay.
//    Otherwise go to START.
//   START -> BYTE x4 (ID, addr[15:8], addr[7:0], data), each byte followed by ACK -> STOP -> NEXT.
//   NEXT: if lut_index==REG_NUM-1, go to DONE. Otherwise increment lut_index and go to LOAD.
//   DONE / ERR: hold. A start pulse goes back to PWDN, resets lut_index to 0 and clears flags.
//   start pulses are ignored while busy=1.
//  Bit timing: one tick every QDIV clk cycles. Each SCL period is 4 ticks:
//   tick0 SCL low, SDA changes; tick1 SCL released; tick2 SCL high; tick3 SCL pulled low.
//   START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
//   Data is sent MSB first.
//  ACK: SDA is released during the 9th bit and sampled at tick2.
//   sda_i=0 means ACK. sda_i=1 means NACK.
//  NACK: send STOP, then retry the same entry from START.
//   After MAX_RETRY retries have all failed, go to ERR. lut_index then holds the failing index.
//  Width rules: lut_index is 8 bits and never wraps, because NEXT stops at REG_NUM-1.
//   Counters are sized with $clog2 of their largest parameter.
//  Bus idle: scl_oe=0 and sda_oe=0 outside START..STOP.
//   No clock stretching is supported; SCL is not read back.
// TESTING
//  CLK_FREQ=400, SCL_FREQ=100 (QDIV=1), PWDN/RST/SETTLE=4, REG_NUM=2; start -> pwdn=1 for 4 cycles,
//   rst_n=0 for 8 cycles total, first START 5 cycles after rst_n rises.
//  Table {16'h3008,8'h82} with a slave model that ACKs every byte -> bits decoded as 78,30,08,82,
//   STOP, then cam_init_done=1 and busy=0 after entry 1.
//  Slave NACKs entry 0 twice, then ACKs -> 3 STARTs for index 0, then DONE, init_err=0.
//  Slave always NACKs, MAX_RETRY=3 -> 4 attempts, init_err=1, lut_index=0, bus released.
//  Entry {16'hFFFF,8'd2} with MS_CYC=10 -> no bus activity for 20 cycles, then the next entry.
//  rst_n=0 asserted mid-byte -> next edge: scl_oe=0, sda_oe=0, pwdn=1, done=0.
//   A start pulse during busy has no effect.

Source files
------------

// File: rtl/cam_sccb_init_ctrl.sv
// rtl/cam_sccb_init_ctrl.sv - OV5640 power-up sequencer and SCCB register table loader
//
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   start              one-cycle pulse; accepted in IDLE, DONE or ERR
//   lut_index/lut_data register table address / {reg_addr[15:0], data[7:0]} one cycle later
//   cmos_pwdn          camera power down (1 = powered down)
//   cmos_rst_n         camera reset (0 = in reset)
//   scl_oe, sda_oe     open-drain pull-down enables for SCL / SDA
//   sda_i              sampled SDA line level
//   busy               sequence in progress
//   cam_init_done      every table entry written
//   init_err           an entry failed after all retries
module cam_sccb_init_ctrl #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         SCL_FREQ   = 100_000,
    parameter logic [7:0] DEV_ADDR   = 8'h78,
    parameter int         REG_NUM    = 256,
    parameter int         PWDN_CYC   = 250_000,
    parameter int         RST_CYC    = 50_000,
    parameter int         SETTLE_CYC = 1_000_000,
    parameter int         MS_CYC     = 50_000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        cmos_pwdn,
    output logic        cmos_rst_n,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        busy,
    output logic        cam_init_done,
    output logic        init_err
);

    localparam int QDIV    = CLK_FREQ / (4 * SCL_FREQ);
    localparam int QW      = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int MAX_A   = (PWDN_CYC > RST_CYC) ? PWDN_CYC : RST_CYC;
    localparam int MAX_B   = (SETTLE_CYC > MS_CYC) ? SETTLE_CYC : MS_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [7:0] LAST_IDX = 8'(REG_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWDN, S_RST, S_SETTLE, S_LOAD, S_DELAY,
        S_START, S_BYTE, S_STOP, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [7:0]      unit;
    logic [QW-1:0]   qcnt;
    logic [1:0]      phase;
    logic [3:0]      bit_cnt;
    logic [1:0]      byte_cnt;
    logic [RW-1:0]   retry;
    logic            nack;
    logic            done_pend;
    logic [23:0]     entry;

    logic            tick;
    logic            phase_end;
    logic            is_ack;
    logic            bit_val;
    logic            bus_state;
    logic [7:0]      cur_byte;

    assign tick      = (qcnt == QW'(QDIV - 1));
    assign phase_end = tick && (phase == 2'd3);
    assign is_ack    = (bit_cnt == 4'd8);
    assign bus_state = (state == S_START) || (state == S_BYTE) || (state == S_STOP);

    always_comb begin
        cur_byte = DEV_ADDR;
        case (byte_cnt)
            2'd1:    cur_byte = entry[23:16];
            2'd2:    cur_byte = entry[15:8];
            2'd3:    cur_byte = entry[7:0];
            default: cur_byte = DEV_ADDR;
        endcase
    end

    // bit_cnt 0 selects bit 7: MSB first
    assign bit_val = cur_byte[~bit_cnt[2:0]];

    always_comb begin
        state_next    = state;
        scl_oe        = 1'b0;
        sda_oe        = 1'b0;
        busy          = 1'b1;
        cmos_pwdn     = 1'b0;
        cmos_rst_n    = 1'b1;
        cam_init_done = 1'b0;
        init_err      = 1'b0;
        case (state)
            S_IDLE: begin
                busy       = 1'b0;
                cmos_pwdn  = 1'b1;
                cmos_rst_n = 1'b0;
                if (start) state_next = S_PWDN;
            end
            S_PWDN: begin
                cmos_pwdn  = 1'b1;
                cmos_rst_n = 1'b0;
                if (cnt == CW'(PWDN_CYC - 1)) state_next = S_RST;
            end
            S_RST: begin
                cmos_rst_n = 1'b0;
                if (cnt == CW'(RST_CYC - 1)) state_next = S_SETTLE;
            end
            S_SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) state_next = S_LOAD;
            S_LOAD: begin
                if (lut_data[23:8] == 16'hFFFF)
                    state_next = (lut_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                else
                    state_next = S_START;
            end
            S_DELAY: begin
                if (cnt == CW'(MS_CYC - 1) && unit == entry[7:0] - 8'd1)
                    state_next = S_NEXT;
            end
            S_START: begin
                // Bus is idle on entry, so pulling SDA at tick0 falls with SCL high
                sda_oe = 1'b1;
                scl_oe = phase[1];
                if (phase_end) state_next = S_BYTE;
            end
            S_BYTE: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = is_ack ? 1'b0 : ~bit_val;
                if (phase_end && is_ack && (nack || byte_cnt == 2'd3))
                    state_next = S_STOP;
            end
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase <= 2'd1);
                if (phase_end) begin
                    if (!nack)
                        state_next = S_NEXT;
                    else if (retry == RW'(MAX_RETRY))
                        state_next = S_ERR;
                    else
                        state_next = S_START;
                end
            end
            S_NEXT: state_next = done_pend ? S_DONE : S_LOAD;
            S_DONE: begin
                busy          = 1'b0;
                cam_init_done = 1'b1;
                if (start) state_next = S_PWDN;
            end
            S_ERR: begin
                busy     = 1'b0;
                init_err = 1'b1;
                if (start) state_next = S_PWDN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            unit      <= '0;
            qcnt      <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            retry     <= '0;
            nack      <= 1'b0;
            done_pend <= 1'b0;
            entry     <= '0;
            lut_index <= '0;
        end else begin
            state <= state_next;

            case (state)
                S_PWDN, S_RST, S_SETTLE: cnt <= (state_next != state) ? '0 : cnt + CW'(1);
                S_DELAY: begin
                    if (cnt == CW'(MS_CYC - 1)) begin
                        cnt  <= '0;
                        unit <= unit + 8'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt  <= '0;
                    unit <= '0;
                end
            endcase

            if (state == S_LOAD) begin
                entry <= lut_data;
                retry <= '0;
            end

            if (state_next == S_PWDN && state != S_PWDN)
                lut_index <= '0;

            // Advance the index on the way into NEXT so the table has the
            // NEXT cycle to respond before LOAD latches it
            if (state_next == S_NEXT) begin
                done_pend <= (lut_index == LAST_IDX);
                if (lut_index != LAST_IDX) lut_index <= lut_index + 8'd1;
            end

            if (state_next == S_START && state != S_START) begin
                qcnt     <= '0;
                phase    <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                nack     <= 1'b0;
                if (state == S_STOP) retry <= retry + RW'(1);
            end else if (bus_state) begin
                qcnt <= tick ? '0 : qcnt + QW'(1);
                if (tick) phase <= phase + 2'd1;
                if (state == S_BYTE && is_ack && tick && phase == 2'd2)
                    nack <= sda_i;
                if (state == S_BYTE && phase_end) begin
                    if (is_ack) begin
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
            end else begin
                qcnt  <= '0;
                phase <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cam_sccb_init_ctrl.sv
// tb/tb_cam_sccb_init_ctrl.sv - directed bench for cam_sccb_init_ctrl with SCCB slave model
`timescale 1ns/1ps
module tb_cam_sccb_init_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic        cmos_pwdn, cmos_rst_n, scl_oe, sda_oe, sda_i;
    logic        busy, cam_init_done, init_err;
    logic        slave_pull = 1'b0;

    logic [23:0] rom [0:1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) lut_data <= rom[lut_index[0]];

    assign sda_i = ~(sda_oe | slave_pull);

    cam_sccb_init_ctrl #(
        .CLK_FREQ(400), .SCL_FREQ(100), .DEV_ADDR(8'h78), .REG_NUM(2),
        .PWDN_CYC(4), .RST_CYC(4), .SETTLE_CYC(4), .MS_CYC(10), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lut_index(lut_index), .lut_data(lut_data),
        .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i),
        .busy(busy), .cam_init_done(cam_init_done), .init_err(init_err)
    );

    // Slave model: decodes START/STOP/bytes and ACKs unless told to NACK the ID byte
    int         start_cnt = 0, stop_cnt = 0, nlog = 0, bitn = 0, fbyte = 0, id_seen = 0;
    int         id_base = 0, nack_limit = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] blog [0:63];
    logic       last_id = 1'b0;
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    logic       scl_now, sda_now;

    always @(negedge clk) begin
        if (!rst_n) begin
            bitn = 0;
            slave_pull = 1'b0;
            scl_prev = 1'b1;
            sda_prev = 1'b1;
        end else begin
            scl_now = ~scl_oe;
            sda_now = ~(sda_oe | slave_pull);
            if (scl_prev && scl_now && sda_prev && !sda_now) begin
                start_cnt++;
                bitn = 0;
                fbyte = 0;
            end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
                stop_cnt++;
            end else if (!scl_prev && scl_now) begin
                if (bitn < 8) begin
                    shreg = {shreg[6:0], sda_now};
                    bitn++;
                    if (bitn == 8) begin
                        if (nlog < 64) blog[nlog] = shreg;
                        nlog++;
                        last_id = (fbyte == 0);
                        fbyte++;
                    end
                end else begin
                    bitn++;
                end
            end else if (scl_prev && !scl_now) begin
                if (bitn == 8) begin
                    slave_pull = !(last_id && (id_seen - id_base) < nack_limit);
                    if (last_id) id_seen++;
                end else if (bitn == 9) begin
                    slave_pull = 1'b0;
                    bitn = 0;
                end
            end
            scl_prev = scl_now;
            sda_prev = sda_now;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called right after pulse_start; returns pwdn-high cycles, rst-low cycles
    // and cycles from cmos_rst_n rising to the first SDA pull
    task automatic measure(output int np, output int nr, output int ks);
        np = 0; nr = 0; ks = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmos_rst_n) break;
            if (cmos_pwdn) np++;
            nr++;
            @(negedge clk);
        end
        for (int i = 0; i < 200; i++) begin
            if (sda_oe) break;
            @(negedge clk);
            ks++;
        end
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(cam_init_done || init_err) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n >= 5000), 32'd0);
    endtask

    int         np, nr, ks, s0, p0, b0;
    logic [7:0] exp_a [0:7] = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h31, 8'h03, 8'h11};
    logic [7:0] exp_b [0:9] = '{8'h78, 8'h78, 8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h31, 8'h03, 8'h11};

    initial begin
        rom[0] = {16'h3008, 8'h82};
        rom[1] = {16'h3103, 8'h11};
        repeat (3) @(negedge clk);
        chk("rst_pwdn", 32'(cmos_pwdn), 32'd1);
        chk("rst_cam_rst_n", 32'(cmos_rst_n), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(cam_init_done), 32'd0);
        chk("rst_err", 32'(init_err), 32'd0);
        chk("rst_index", 32'(lut_index), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: two plain entries, slave ACKs everything
        s0 = start_cnt; p0 = stop_cnt; b0 = nlog;
        pulse_start();
        chk("a_busy_run", 32'(busy), 32'd1);
        measure(np, nr, ks);
        chk("a_pwdn_cycles", 32'(np), 32'd4);
        chk("a_rst_cycles", 32'(nr), 32'd8);
        chk("a_first_start", 32'(ks), 32'd5);
        wait_end("a_timeout");
        chk("a_done", 32'(cam_init_done), 32'd1);
        chk("a_busy_end", 32'(busy), 32'd0);
        chk("a_err", 32'(init_err), 32'd0);
        chk("a_index", 32'(lut_index), 32'd1);
        chk("a_nbytes", 32'(nlog - b0), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("a_byte%0d", i), 32'(blog[b0 + i]), 32'(exp_a[i]));
        chk("a_starts", 32'(start_cnt - s0), 32'd2);
        chk("a_stops", 32'(stop_cnt - p0), 32'd2);

        // B: entry 0 NACKed twice, plus a start pulse while busy
        s0 = start_cnt; p0 = stop_cnt; b0 = nlog;
        id_base = id_seen; nack_limit = 2;
        pulse_start();
        chk("b_done_cleared", 32'(cam_init_done), 32'd0);
        measure(np, nr, ks);
        repeat (40) @(negedge clk);
        chk("b_busy_mid", 32'(busy), 32'd1);
        pulse_start();
        wait_end("b_timeout");
        chk("b_done", 32'(cam_init_done), 32'd1);
        chk("b_err", 32'(init_err), 32'd0);
        chk("b_starts", 32'(start_cnt - s0), 32'd4);
        chk("b_stops", 32'(stop_cnt - p0), 32'd4);
        chk("b_nbytes", 32'(nlog - b0), 32'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("b_byte%0d", i), 32'(blog[b0 + i]), 32'(exp_b[i]));

        // C: slave NACKs forever
        s0 = start_cnt; p0 = stop_cnt;
        id_base = id_seen; nack_limit = 1000;
        pulse_start();
        wait_end("c_timeout");
        chk("c_err", 32'(init_err), 32'd1);
        chk("c_done", 32'(cam_init_done), 32'd0);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_index", 32'(lut_index), 32'd0);
        chk("c_scl_oe", 32'(scl_oe), 32'd0);
        chk("c_sda_oe", 32'(sda_oe), 32'd0);
        chk("c_starts", 32'(start_cnt - s0), 32'd4);
        chk("c_stops", 32'(stop_cnt - p0), 32'd4);

        // D: delay entry of 2 ms units (20 cycles) before a normal entry
        rom[0] = {16'hFFFF, 8'h02};
        rom[1] = {16'h3008, 8'h82};
        s0 = start_cnt; b0 = nlog;
        id_base = id_seen; nack_limit = 0;
        pulse_start();
        chk("d_err_cleared", 32'(init_err), 32'd0);
        measure(np, nr, ks);
        chk("d_first_start", 32'(ks), 32'd27);
        wait_end("d_timeout");
        chk("d_done", 32'(cam_init_done), 32'd1);
        chk("d_starts", 32'(start_cnt - s0), 32'd1);
        chk("d_nbytes", 32'(nlog - b0), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("d_byte%0d", i), 32'(blog[b0 + i]), 32'(exp_a[i]));

        // E: reset in the middle of the second byte
        rom[0] = {16'h3008, 8'h82};
        rom[1] = {16'h3103, 8'h11};
        b0 = nlog;
        pulse_start();
        np = 0;
        while (!((nlog - b0) >= 1 && bitn == 3) && np < 2000) begin
            @(negedge clk);
            np++;
        end
        chk("e_reach_mid_byte", 32'(np >= 2000), 32'd0);
        chk("e_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_scl_oe", 32'(scl_oe), 32'd0);
        chk("e_sda_oe", 32'(sda_oe), 32'd0);
        chk("e_pwdn", 32'(cmos_pwdn), 32'd1);
        chk("e_cam_rst_n", 32'(cmos_rst_n), 32'd0);
        chk("e_done", 32'(cam_init_done), 32'd0);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_index", 32'(lut_index), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
